sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATASIZE, default 8: data word width in bits.
REQ-002 Parameter ADDRSIZE, default 4: address bits; depth DEPTH = 2^ADDRSIZE.
REQ-003 Parameter AFULL_THRESH, default DEPTH-2: almost_full asserts when count >= this value.
REQ-004 Parameter AEMPTY_THRESH, default 2: almost_empty asserts when count <= this value.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 winc  in  1  write request.
REQ-008 wdata  in  DATASIZE  write data.
REQ-009 rinc  in  1  read request.
REQ-010 rdata  out  DATASIZE  registered read data.
REQ-011 rvalid  out  1  one-cycle pulse: rdata holds a newly read word.
REQ-012 wfull / rempty  out  1 each  full / empty status.
REQ-013 almost_full / almost_empty  out  1 each  threshold status.
REQ-014 count  out  ADDRSIZE+1  current occupancy, 0..DEPTH.

Function
REQ-015 Write accepted iff winc && !wfull; word stored at wptr, wptr increments.
REQ-016 Read accepted iff rinc && !rempty; word at rptr loaded into rdata on the same edge, rptr increments, rvalid = 1 the following cycle.
REQ-017 Read latency is one clock: rdata/rvalid valid in the cycle after the accepting edge.
REQ-018 rdata holds its last value when no read is accepted; rvalid = 0.
REQ-019 Pointers ADDRSIZE+1 bits binary; low ADDRSIZE bits address storage; wrap from DEPTH-1 to 0 silently, MSB toggles.
REQ-020 Full when pointer MSBs differ and low bits are equal; empty when pointers are equal.
REQ-021 count, wfull, rempty, almost_full, almost_empty are registered and all reflect the same post-edge occupancy; none lags the others.
REQ-022 Simultaneous accepted write and read: count unchanged, both pointers advance.
REQ-023 Empty with winc && rinc: only the write is accepted; no write-through to rdata; rvalid stays 0.
REQ-024 Full with winc && rinc: only the read is accepted; the write is dropped.
REQ-025 Write when full and read when empty are ignored: no state change, no corruption.
REQ-026 Storage contents are not reset; reads return only previously written words.

Reset
REQ-027 While rst = 1: wptr = rptr = 0, count = 0, rempty = 1, wfull = 0, almost_empty = 1, almost_full = (AFULL_THRESH == 0), rdata = 0, rvalid = 0.
REQ-028 Reset asserted mid-operation empties the FIFO immediately and asynchronously; accepts nothing until the first rising edge after deassertion.

Configuration
REQ-029 Macro SYNC_FIFO_ERR_FLAGS_EN defined: adds outputs overflow and underflow (1 bit each), sticky; set on winc while full (overflow) or rinc while empty (underflow); cleared only by rst.
REQ-030 Macro undefined: neither port exists; dropped requests are silent; all other behaviour is identical.

Structure
REQ-031 Package sync_fifo_pkg holds the depth/count-width derivation and the threshold-legality check (AFULL_THRESH <= DEPTH, AEMPTY_THRESH < DEPTH); violations raise an elaboration error.
REQ-032 Storage is a single sub-module sync_fifo_ram: one write port (clk, write enable, address, data) and one registered read port (read enable, address, data), no reset on the array.
REQ-033 Pointer, count, flag and error logic reside in sync_fifo; no latches, no combinational output paths from inputs.

Verification (DATASIZE=8, ADDRSIZE=4, AFULL_THRESH=14, AEMPTY_THRESH=2)
REQ-034 Reset, then write 0x01..0x10 (16 words) -> wfull = 1 after the 16th edge, count = 16, almost_full set after the 14th write; 17th winc ignored (overflow = 1 if SYNC_FIFO_ERR_FLAGS_EN).
REQ-035 Read 16 times from full -> rdata sequence 0x01..0x10, each with rvalid one cycle after its rinc; rempty = 1 after the 16th; further rinc -> rvalid = 0, rdata holds 0x10.
REQ-036 Hold count = 8, drive winc && rinc for 40 cycles -> count stays 8, pointers wrap twice, data order preserved.
REQ-037 Empty FIFO, winc && rinc with wdata = 0xA5 -> count = 1, rvalid = 0; next cycle rinc -> rdata = 0xA5, rvalid = 1.
REQ-038 Full FIFO, winc && rinc -> read accepted, write dropped, count = 15.
REQ-039 Assert rst asynchronously with count = 9 -> count = 0, rempty = 1, rvalid = 0 before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and threshold legality check for sync_fifo.
// Optional error flags: define SYNC_FIFO_ERR_FLAGS_EN (see sync_fifo.sv).
package sync_fifo_pkg;

    // Registered status bundle, all updated from the same next occupancy.
    typedef struct packed {
        logic wfull;
        logic rempty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    function automatic int depth_of(input int addrsize);
        return 1 << addrsize;
    endfunction

    // Pointers and count carry one extra bit to tell full from empty.
    function automatic int count_width(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic bit thresh_ok(
        input int addrsize,
        input int afull,
        input int aempty
    );
        return (addrsize >= 1) &&
               (afull >= 0) && (afull <= depth_of(addrsize)) &&
               (aempty >= 0) && (aempty < depth_of(addrsize));
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/status bundle between a FIFO user (master) and sync_fifo (slave).
// overflow/underflow exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
);
    import sync_fifo_pkg::*;

    logic                               winc;
    logic [DATASIZE-1:0]                wdata;
    logic                               rinc;
    logic [DATASIZE-1:0]                rdata;
    logic                               rvalid;
    logic                               wfull;
    logic                               rempty;
    logic                               almost_full;
    logic                               almost_empty;
    logic [count_width(ADDRSIZE)-1:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                               overflow;
    logic                               underflow;

    modport master (
        output winc, wdata, rinc,
        input  rdata, rvalid, wfull, rempty,
        input  almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc,
        output rdata, rvalid, wfull, rempty,
        output almost_full, almost_empty, count,
        output overflow, underflow
    );
`else
    modport master (
        output winc, wdata, rinc,
        input  rdata, rvalid, wfull, rempty,
        input  almost_full, almost_empty, count
    );

    modport slave (
        input  winc, wdata, rinc,
        output rdata, rvalid, wfull, rempty,
        output almost_full, almost_empty, count
    );
`endif

endinterface

// File: rtl/sync_fifo_ram.sv
// Storage array: one write port, one registered read port.
// Ports: clk, rst (read register only), we/waddr/wdata, re/raddr/rdata.
module sync_fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // The array itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register resets; it holds when re is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, status flags and read valid.
// Ports: clk, rst (async, active-high), bus (sync_fifo_if.slave).
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AFULL_THRESH  = depth_of(ADDRSIZE) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input logic        clk,
    input logic        rst,
    sync_fifo_if.slave bus
);

    localparam int PW = count_width(ADDRSIZE);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AF_T    = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_T    = PW'(AEMPTY_THRESH);

    localparam fifo_flags_t FLAGS_RST = '{
        wfull:  1'b0,
        rempty: 1'b1,
        afull:  (AFULL_THRESH == 0),
        aempty: 1'b1
    };

    if (!thresh_ok(ADDRSIZE, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_cfg
        $error("sync_fifo: illegal AFULL_THRESH/AEMPTY_THRESH for depth");
    end

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_n;
    logic [PW-1:0] rptr_n;
    logic [PW-1:0] count;
    logic [PW-1:0] count_n;
    logic          wr_en;
    logic          rd_en;
    logic          rvalid;
    fifo_flags_t   flags;
    fifo_flags_t   flags_n;

    // Acceptance uses the registered flags, so full/empty with both
    // requests resolves to read-only / write-only respectively.
    assign wr_en = bus.winc && !flags.wfull;
    assign rd_en = bus.rinc && !flags.rempty;

    assign wptr_n  = wr_en ? wptr + PTR_ONE : wptr;
    assign rptr_n  = rd_en ? rptr + PTR_ONE : rptr;
    assign count_n = wptr_n - rptr_n;

    // Every flag derives from the post-edge pointers so none lags.
    always_comb begin
        flags_n        = FLAGS_RST;
        flags_n.wfull  = (wptr_n[PW-1] != rptr_n[PW-1]) &&
                         (wptr_n[ADDRSIZE-1:0] == rptr_n[ADDRSIZE-1:0]);
        flags_n.rempty = (wptr_n == rptr_n);
        flags_n.afull  = (count_n >= AF_T);
        flags_n.aempty = (count_n <= AE_T);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            flags  <= FLAGS_RST;
            rvalid <= 1'b0;
        end else begin
            wptr   <= wptr_n;
            rptr   <= rptr_n;
            count  <= count_n;
            flags  <= flags_n;
            rvalid <= rd_en;
        end
    end

    sync_fifo_ram #(
        .DW (DATASIZE),
        .AW (ADDRSIZE)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wptr[ADDRSIZE-1:0]),
        .wdata (bus.wdata),
        .re    (rd_en),
        .raddr (rptr[ADDRSIZE-1:0]),
        .rdata (bus.rdata)
    );

    assign bus.rvalid       = rvalid;
    assign bus.count        = count;
    assign bus.wfull        = flags.wfull;
    assign bus.rempty       = flags.rempty;
    assign bus.almost_full  = flags.afull;
    assign bus.almost_empty = flags.aempty;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow;
    logic underflow;

    // Sticky until reset; a request against the registered flag counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.winc && flags.wfull) begin
                overflow <= 1'b1;
            end
            if (bus.rinc && flags.rempty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DATASIZE=8, ADDRSIZE=4).
// Scoreboard queue of expected read words, checked on each negedge.
module tb_sync_fifo;

    logic clk;
    logic rst;

    int total;
    int bad;

    sync_fifo_if #(.DATASIZE(8), .ADDRSIZE(4)) bus ();

    sync_fifo #(
        .DATASIZE      (8),
        .ADDRSIZE      (4),
        .AFULL_THRESH  (14),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model contents, and words the DUT owes us on rdata.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       exp_rv;
    logic [7:0] last_rd;

    always @(negedge clk) begin
        logic [7:0] e;
        total++;
        if (bus.rvalid !== exp_rv) begin
            bad++;
            $display("FAIL rvalid got=%b exp=%b t=%0t", bus.rvalid, exp_rv, $time);
        end else if (exp_rv) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty got=%h t=%0t", bus.rdata, $time);
            end else begin
                e = exp_q.pop_front();
                last_rd = e;
                if (bus.rdata !== e) begin
                    bad++;
                    $display("FAIL rdata got=%h exp=%h t=%0t", bus.rdata, e, $time);
                end
            end
        end else begin
            total++;
            if (bus.rdata !== last_rd) begin
                bad++;
                $display("FAIL rdata_hold got=%h exp=%h t=%0t", bus.rdata, last_rd, $time);
            end
        end
    end

    task automatic cyc(input bit w, input logic [7:0] d, input bit r);
        bit wacc;
        bit racc;
        bus.winc  = w;
        bus.wdata = d;
        bus.rinc  = r;
        wacc = w && (mq.size() < 16);
        racc = r && (mq.size() > 0);
        @(posedge clk);
        if (racc) exp_q.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        exp_rv = racc;
        #1;
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (bus.count !== 5'd0 || bus.rempty !== 1'b1 ||
            bus.wfull !== 1'b0 || bus.almost_empty !== 1'b1 ||
            bus.almost_full !== 1'b0 || bus.rdata !== 8'h00 ||
            bus.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset cnt=%0d re=%b wf=%b ae=%b af=%b rd=%h rv=%b exp=0,1,0,1,0,00,0",
                     bus.count, bus.rempty, bus.wfull, bus.almost_empty,
                     bus.almost_full, bus.rdata, bus.rvalid);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_err ovf=%b udf=%b exp=0,0", bus.overflow, bus.underflow);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            total++;
            if (bus.count !== 5'(i) || bus.wfull !== (i == 16) ||
                bus.almost_full !== (i >= 14) ||
                bus.almost_empty !== (i <= 2) || bus.rempty !== 1'b0) begin
                bad++;
                $display("FAIL fill[%0d] cnt=%0d wf=%b af=%b ae=%b re=%b exp_cnt=%0d",
                         i, bus.count, bus.wfull, bus.almost_full,
                         bus.almost_empty, bus.rempty, i);
            end
        end
        cyc(1'b1, 8'hEE, 1'b0);
        total++;
        if (bus.count !== 5'd16 || bus.wfull !== 1'b1) begin
            bad++;
            $display("FAIL overfill cnt=%0d wf=%b exp=16,1", bus.count, bus.wfull);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++;
        if (bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow ovf=%b udf=%b exp=1,0", bus.overflow, bus.underflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            total++;
            if (bus.count !== 5'(16 - i) || bus.rempty !== (i == 16) ||
                bus.wfull !== 1'b0 || bus.almost_full !== (16 - i >= 14) ||
                bus.almost_empty !== (16 - i <= 2)) begin
                bad++;
                $display("FAIL drain[%0d] cnt=%0d re=%b wf=%b af=%b ae=%b exp_cnt=%0d",
                         i, bus.count, bus.rempty, bus.wfull,
                         bus.almost_full, bus.almost_empty, 16 - i);
            end
        end
        cyc(1'b0, 8'h00, 1'b1);
        total++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 8'h10 || bus.count !== 5'd0) begin
            bad++;
            $display("FAIL underread rv=%b rd=%h cnt=%0d exp=0,10,0",
                     bus.rvalid, bus.rdata, bus.count);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++;
        if (bus.underflow !== 1'b1) begin
            bad++;
            $display("FAIL underflow got=%b exp=1", bus.underflow);
        end
`endif
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(8'h40 + i), 1'b1);
            total++;
            if (bus.count !== 5'd8 || bus.rvalid !== 1'b1) begin
                bad++;
                $display("FAIL stream[%0d] cnt=%0d rv=%b exp=8,1", i, bus.count, bus.rvalid);
            end
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
        total++;
        if (bus.rempty !== 1'b1 || bus.rdata !== 8'h67) begin
            bad++;
            $display("FAIL stream_end re=%b rd=%h exp=1,67", bus.rempty, bus.rdata);
        end
    endtask

    task automatic test_empty_rw();
        cyc(1'b1, 8'hA5, 1'b1);
        total++;
        if (bus.count !== 5'd1 || bus.rvalid !== 1'b0 || bus.rempty !== 1'b0) begin
            bad++;
            $display("FAIL empty_rw cnt=%0d rv=%b re=%b exp=1,0,0",
                     bus.count, bus.rvalid, bus.rempty);
        end
        cyc(1'b0, 8'h00, 1'b1);
        total++;
        if (bus.rdata !== 8'hA5 || bus.rvalid !== 1'b1 || bus.count !== 5'd0) begin
            bad++;
            $display("FAIL empty_rw_rd rd=%h rv=%b cnt=%0d exp=a5,1,0",
                     bus.rdata, bus.rvalid, bus.count);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
        cyc(1'b1, 8'h77, 1'b1);
        total++;
        if (bus.count !== 5'd15 || bus.wfull !== 1'b0 || bus.rdata !== 8'h80) begin
            bad++;
            $display("FAIL full_rw cnt=%0d wf=%b rd=%h exp=15,0,80",
                     bus.count, bus.wfull, bus.rdata);
        end
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
        total++;
        if (bus.rempty !== 1'b1 || bus.rdata !== 8'h8F) begin
            bad++;
            $display("FAIL full_rw_end re=%b rd=%h exp=1,8f", bus.rempty, bus.rdata);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        #2;
        mq.delete();
        exp_q.delete();
        exp_rv  = 1'b0;
        last_rd = 8'h00;
        rst = 1'b1;
        #1;
        total++;
        if (bus.count !== 5'd0 || bus.rempty !== 1'b1 ||
            bus.rvalid !== 1'b0 || bus.rdata !== 8'h00) begin
            bad++;
            $display("FAIL async_rst cnt=%0d re=%b rv=%b rd=%h exp=0,1,0,00",
                     bus.count, bus.rempty, bus.rvalid, bus.rdata);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_err ovf=%b udf=%b exp=0,0",
                     bus.overflow, bus.underflow);
        end
`endif
        bus.winc  = 1'b1;
        bus.wdata = 8'h33;
        @(posedge clk);
        #1;
        total++;
        if (bus.count !== 5'd0) begin
            bad++;
            $display("FAIL rst_hold cnt=%0d exp=0", bus.count);
        end
        bus.winc = 1'b0;
        #2;
        rst = 1'b0;
        cyc(1'b1, 8'h5A, 1'b0);
        total++;
        if (bus.count !== 5'd1) begin
            bad++;
            $display("FAIL post_rst cnt=%0d exp=1", bus.count);
        end
        cyc(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        exp_rv    = 1'b0;
        last_rd   = 8'h00;
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.wdata = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_empty_rw();
        test_full_rw();
        test_async_reset();
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
